mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles a grant waits for bus_ack before aborting (range 1..15).
REQ-002 Parameter STARVE_MAX, default 3: maximum consecutive data grants while fetch is pending.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 if_req  in  1  fetch request; held until if_ready.
REQ-006 if_addr  in  32  fetch byte address.
REQ-007 if_rdata  out  32  fetched instruction; valid while if_ready=1.
REQ-008 if_ready  out  1  one-cycle fetch completion pulse.
REQ-009 mem_req  in  1  data request from MEM stage; held until mem_ready.
REQ-010 mem_we  in  1  1=store (SW), 0=load (LW).
REQ-011 mem_addr  in  32  data byte address.
REQ-012 mem_wdata  in  32  store data.
REQ-013 mem_rdata  out  32  load data; valid while mem_ready=1.
REQ-014 mem_ready  out  1  one-cycle data completion pulse.
REQ-015 bus_req  out  1  registered external bus request.
REQ-016 bus_we  out  1  registered write enable.
REQ-017 bus_addr  out  32  registered address.
REQ-018 bus_wdata  out  32  registered write data.
REQ-019 bus_rdata  in  32  read data; valid in the bus_ack cycle.
REQ-020 bus_ack  in  1  transfer complete, one cycle.
REQ-021 bus_err  out  1  one-cycle pulse coincident with if_ready/mem_ready when the transfer timed out.
REQ-022 stallreq_if  out  1  combinational: if_req & ~if_ready.
REQ-023 stallreq_mem  out  1  combinational: mem_req & ~mem_ready.

Function
REQ-024 FSM states SHALL be IDLE, GNT_IF, GNT_MEM and RESP.
REQ-025 In IDLE, mem_req SHALL win over if_req, except when if_req=1 and the consecutive-data-grant count equals STARVE_MAX, in which case fetch SHALL win.
REQ-026 On a grant, the next cycle SHALL enter GNT_IF or GNT_MEM with bus_req=1 and bus_addr/bus_we/bus_wdata latched from the winner; fetch grants SHALL drive bus_we=0 and bus_wdata=0.
REQ-027 Bus outputs SHALL remain stable throughout GNT_* until bus_ack or timeout.
REQ-028 On bus_ack in GNT_*, the FSM SHALL capture bus_rdata into the winner's rdata register, drop bus_req, and enter RESP on the next edge.
REQ-029 In RESP, exactly the winner's ready SHALL be 1 for one cycle; RESP SHALL always return to IDLE, and requests SHALL be ignored in RESP.
REQ-030 Minimum latency SHALL be 3 cycles from req sampled in IDLE to ready (grant, ack in first GNT cycle, RESP).
REQ-031 A wait counter SHALL clear on entry to GNT_* and increment each GNT_* cycle without bus_ack.
REQ-032 When the wait count reaches TIMEOUT without bus_ack, the FSM SHALL drop bus_req, load 0 into the winner's rdata, enter RESP and pulse bus_err with ready.
REQ-033 If bus_ack arrives in the same cycle the wait count reaches TIMEOUT, bus_ack SHALL win and bus_err SHALL stay 0.
REQ-034 The consecutive-data-grant counter (2 bits, saturating):
  - SHALL increment on each data grant while if_req=1.
  - SHALL clear on any fetch grant, or on a data grant with if_req=0.
REQ-035 Store grants SHALL still complete through RESP with mem_ready; mem_rdata SHALL carry the captured bus_rdata.
REQ-036 bus_ack received in IDLE or RESP SHALL be ignored.

Reset
REQ-037 While rst=1, on each clock edge:
  - state SHALL go to IDLE.
  - bus_req, bus_we, if_ready, mem_ready and bus_err SHALL be 0.
  - bus_addr, bus_wdata, if_rdata and mem_rdata SHALL be 0.
  - the wait and consecutive-grant counters SHALL be 0.
REQ-038 A reset asserted mid-transfer SHALL abandon the transfer without any ready pulse; bus_req SHALL be 0 on the edge after rst is sampled.

Verification
REQ-039 Single load: mem_req=1, mem_we=0, addr=0x100, and bus_ack with rdata=0xDEADBEEF arrives in the first GNT cycle -> mem_ready=1 and mem_rdata=0xDEADBEEF exactly 3 cycles after the request; if_ready stays 0.
REQ-040 Simultaneous if_req and mem_req, counter=0 -> data granted first (bus_addr=mem_addr), then fetch granted from the next IDLE.
REQ-041 Starvation: mem_req re-asserted continuously with if_req held for 4 arbitrations -> 3 data grants, then fetch granted on the 4th.
REQ-042 Timeout: fetch with bus_ack never asserted -> after 15 GNT cycles, if_ready=1, bus_err=1, if_rdata=0, and bus_req=0 in RESP.
REQ-043 Ack/timeout tie: bus_ack in the 15th GNT cycle with rdata=0x1234 -> bus_err=0 and if_rdata=0x1234.
REQ-044 Reset in the 2nd GNT_MEM cycle -> bus_req=0 on the next edge, no mem_ready, and state=IDLE.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IF fetches and MEM loads/stores share one external bus.
// Data wins by default; fetch is forced through after STARVE_MAX back-to-back data grants.
module mem_arbiter #(
    parameter int unsigned TIMEOUT    = 15,
    parameter int unsigned STARVE_MAX = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic [31:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    output logic [31:0] mem_rdata,
    output logic        mem_ready,
    output logic        bus_req,
    output logic        bus_we,
    output logic [31:0] bus_addr,
    output logic [31:0] bus_wdata,
    input  logic [31:0] bus_rdata,
    input  logic        bus_ack,
    output logic        bus_err,
    output logic        stallreq_if,
    output logic        stallreq_mem
);

    typedef enum logic [1:0] {StIdle, StGntIf, StGntMem, StResp} state_e;

    localparam logic [3:0] WaitLast  = 4'(TIMEOUT - 1);
    localparam logic [1:0] StarveMax = 2'(STARVE_MAX);

    state_e      state_q, state_d;
    logic [3:0]  wait_q, wait_d;
    logic [1:0]  streak_q, streak_d;
    logic        bus_req_q, bus_req_d;
    logic        bus_we_q, bus_we_d;
    logic [31:0] bus_addr_q, bus_addr_d;
    logic [31:0] bus_wdata_q, bus_wdata_d;
    logic [31:0] if_rdata_q, if_rdata_d;
    logic [31:0] mem_rdata_q, mem_rdata_d;
    logic        if_ready_q, if_ready_d;
    logic        mem_ready_q, mem_ready_d;
    logic        bus_err_q, bus_err_d;

    always_comb begin
        state_d     = state_q;
        wait_d      = wait_q;
        streak_d    = streak_q;
        bus_req_d   = bus_req_q;
        bus_we_d    = bus_we_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        if_ready_d  = 1'b0;
        mem_ready_d = 1'b0;
        bus_err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (if_req && (!mem_req || streak_q == StarveMax)) begin
                    state_d     = StGntIf;
                    bus_req_d   = 1'b1;
                    bus_we_d    = 1'b0;
                    bus_addr_d  = if_addr;
                    bus_wdata_d = '0;
                    wait_d      = '0;
                    streak_d    = '0;
                end else if (mem_req) begin
                    state_d     = StGntMem;
                    bus_req_d   = 1'b1;
                    bus_we_d    = mem_we;
                    bus_addr_d  = mem_addr;
                    bus_wdata_d = mem_wdata;
                    wait_d      = '0;
                    // Only back-to-back data grants that actually block a fetch count
                    if (!if_req) begin
                        streak_d = '0;
                    end else if (streak_q != 2'd3) begin
                        streak_d = streak_q + 2'd1;
                    end
                end
            end
            StGntIf, StGntMem: begin
                if (bus_ack || wait_q == WaitLast) begin
                    // Ack beats a simultaneous timeout
                    state_d   = StResp;
                    bus_req_d = 1'b0;
                    bus_err_d = !bus_ack;
                    if (state_q == StGntIf) begin
                        if_ready_d = 1'b1;
                        if_rdata_d = bus_ack ? bus_rdata : '0;
                    end else begin
                        mem_ready_d = 1'b1;
                        mem_rdata_d = bus_ack ? bus_rdata : '0;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            StResp: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            wait_q      <= '0;
            streak_q    <= '0;
            bus_req_q   <= 1'b0;
            bus_we_q    <= 1'b0;
            bus_addr_q  <= '0;
            bus_wdata_q <= '0;
            if_rdata_q  <= '0;
            mem_rdata_q <= '0;
            if_ready_q  <= 1'b0;
            mem_ready_q <= 1'b0;
            bus_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            streak_q    <= streak_d;
            bus_req_q   <= bus_req_d;
            bus_we_q    <= bus_we_d;
            bus_addr_q  <= bus_addr_d;
            bus_wdata_q <= bus_wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
            if_ready_q  <= if_ready_d;
            mem_ready_q <= mem_ready_d;
            bus_err_q   <= bus_err_d;
        end
    end

    assign if_rdata     = if_rdata_q;
    assign if_ready     = if_ready_q;
    assign mem_rdata    = mem_rdata_q;
    assign mem_ready    = mem_ready_q;
    assign bus_req      = bus_req_q;
    assign bus_we       = bus_we_q;
    assign bus_addr     = bus_addr_q;
    assign bus_wdata    = bus_wdata_q;
    assign bus_err      = bus_err_q;
    assign stallreq_if  = if_req & ~if_ready_q;
    assign stallreq_mem = mem_req & ~mem_ready_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: a transaction-level model predicts each grant and
// response; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_arbiter;
    localparam int TIMEOUT    = 15;
    localparam int STARVE_MAX = 3;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        if_req = 1'b0, mem_req = 1'b0, mem_we = 1'b0, bus_ack = 1'b0;
    logic [31:0] if_addr = '0, mem_addr = '0, mem_wdata = '0, bus_rdata = '0;
    logic [31:0] if_rdata, mem_rdata, bus_addr, bus_wdata;
    logic        if_ready, mem_ready, bus_req, bus_we, bus_err, stallreq_if, stallreq_mem;

    mem_arbiter #(.TIMEOUT(TIMEOUT), .STARVE_MAX(STARVE_MAX)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr), .bus_wdata(bus_wdata),
        .bus_rdata(bus_rdata), .bus_ack(bus_ack), .bus_err(bus_err),
        .stallreq_if(stallreq_if), .stallreq_mem(stallreq_mem)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
    } gnt_t;

    typedef struct {
        int          cyc;
        logic        fetch;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

    gnt_t gq[$];
    rsp_t rq[$];
    int   cyc = 0;
    int   n_vec = 0;
    int   n_err = 0;
    int   streak = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Monitor
    initial begin
        logic prev_req;
        logic exp_if_rdy, exp_mem_rdy;
        gnt_t cur, g;
        rsp_t e;
        prev_req = 1'b0;
        cur = '{cyc: 0, addr: '0, we: 1'b0, wdata: '0};
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_req = 1'b0;
                continue;
            end
            exp_if_rdy  = 1'b0;
            exp_mem_rdy = 1'b0;
            if (rq.size() > 0 && rq[0].cyc <= cyc) begin
                e = rq.pop_front();
                exp_if_rdy  = e.fetch;
                exp_mem_rdy = !e.fetch;
                chk("resp_cycle", cyc, e.cyc);
                chk("if_ready", {31'd0, if_ready}, {31'd0, exp_if_rdy});
                chk("mem_ready", {31'd0, mem_ready}, {31'd0, exp_mem_rdy});
                chk("bus_err", {31'd0, bus_err}, {31'd0, e.err});
                chk("rdata", e.fetch ? if_rdata : mem_rdata, e.rdata);
                chk("bus_req_in_resp", {31'd0, bus_req}, 32'd0);
            end else if (if_ready || mem_ready) begin
                chk("unexpected_ready", {30'd0, if_ready, mem_ready}, 32'd0);
            end
            chk("stallreq_if", {31'd0, stallreq_if}, {31'd0, if_req & ~exp_if_rdy});
            chk("stallreq_mem", {31'd0, stallreq_mem}, {31'd0, mem_req & ~exp_mem_rdy});
            if (bus_req && !prev_req) begin
                if (gq.size() == 0) begin
                    chk("unexpected_grant", {31'd0, bus_req}, 32'd0);
                end else begin
                    g = gq.pop_front();
                    chk("grant_cycle", cyc, g.cyc);
                    chk("bus_addr", bus_addr, g.addr);
                    chk("bus_we", {31'd0, bus_we}, {31'd0, g.we});
                    chk("bus_wdata", bus_wdata, g.wdata);
                    cur = g;
                end
            end else if (bus_req) begin
                chk("bus_addr_stable", bus_addr, cur.addr);
                chk("bus_wdata_stable", bus_wdata, cur.wdata);
                chk("bus_we_stable", {31'd0, bus_we}, {31'd0, cur.we});
            end else if (gq.size() > 0 && gq[0].cyc <= cyc) begin
                g = gq.pop_front();
                chk("missing_grant", {31'd0, bus_req}, 32'd1);
            end
            prev_req = bus_req;
        end
    end

    task automatic check_reset_vals();
        chk("rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("rst_bus_we", {31'd0, bus_we}, 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_if_ready", {31'd0, if_ready}, 32'd0);
        chk("rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        chk("rst_bus_err", {31'd0, bus_err}, 32'd0);
        chk("rst_if_rdata", if_rdata, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
    endtask

    // One arbitration from IDLE with requests already driven; the bus slave acks in
    // GNT cycle d (d > TIMEOUT means never).
    task automatic do_txn(input int d, input logic [31:0] rd);
        logic fetch;
        int   n;
        gnt_t g;
        rsp_t r;
        if (!if_req && !mem_req) begin
            bus_ack = 1'($urandom_range(0, 1));
            step();
            bus_ack = 1'b0;
            return;
        end
        fetch = if_req && (!mem_req || streak == STARVE_MAX);
        if (fetch || !if_req) streak = 0;
        else if (streak < 3) streak = streak + 1;
        n = (d > TIMEOUT) ? TIMEOUT : d;
        g.cyc   = cyc + 1;
        g.addr  = fetch ? if_addr : mem_addr;
        g.we    = fetch ? 1'b0 : mem_we;
        g.wdata = fetch ? 32'd0 : mem_wdata;
        gq.push_back(g);
        r.cyc   = cyc + 1 + n;
        r.fetch = fetch;
        r.err   = (d > TIMEOUT);
        r.rdata = r.err ? 32'd0 : rd;
        rq.push_back(r);
        bus_ack = 1'($urandom_range(0, 1));
        step();
        for (int k = 1; k <= n; k++) begin
            bus_ack   = (k == d);
            bus_rdata = (k == d) ? rd : $urandom;
            step();
        end
        // Stray acks in RESP must be ignored
        bus_ack   = 1'($urandom_range(0, 1));
        bus_rdata = $urandom;
        if (fetch) if_req = 1'b0;
        else mem_req = 1'b0;
        step();
        bus_ack = 1'b0;
    endtask

    task automatic random_round();
        int sel, d;
        if (!if_req && $urandom_range(0, 1) == 1) begin
            if_req  = 1'b1;
            if_addr = $urandom & 32'hFFFF_FFFC;
        end
        if (!mem_req && $urandom_range(0, 3) != 0) begin
            mem_req   = 1'b1;
            mem_we    = 1'($urandom_range(0, 1));
            mem_addr  = $urandom;
            mem_wdata = $urandom;
        end
        sel = $urandom_range(0, 9);
        if (sel < 5) d = 1;
        else if (sel < 8) d = $urandom_range(2, 14);
        else if (sel == 8) d = TIMEOUT;
        else d = TIMEOUT + 1;
        do_txn(d, $urandom);
    endtask

    initial begin
        step();
        step();
        check_reset_vals();
        rst = 1'b0;
        step();

        // Single load, ack in first GNT cycle
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h100; mem_wdata = 32'h5555_AAAA;
        do_txn(1, 32'hDEAD_BEEF);
        // Fetch that never sees an ack
        if_req = 1'b1; if_addr = 32'h200;
        do_txn(TIMEOUT + 1, 32'hFFFF_FFFF);
        // Ack on the last possible GNT cycle
        if_req = 1'b1; if_addr = 32'h204;
        do_txn(TIMEOUT, 32'h1234);
        // Both requesting: data first, then fetch
        if_req = 1'b1; if_addr = 32'h300;
        mem_req = 1'b1; mem_we = 1'b1; mem_addr = 32'h400; mem_wdata = 32'hCAFE_F00D;
        do_txn(2, 32'h0BAD_0BAD);
        do_txn(1, 32'h600D_600D);
        // Starvation: data streams continuously while fetch waits
        if_req = 1'b1; if_addr = 32'h500;
        for (int i = 0; i < 4; i++) begin
            mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h800 + 32'(i * 4);
            do_txn(1, 32'hA000_0000 + 32'(i));
        end
        mem_req = 1'b0;
        step();

        for (int i = 0; i < 300; i++) random_round();

        // Reset in the second GNT_MEM cycle
        if_req = 1'b0; if_addr = '0;
        while (mem_req || if_req) do_txn(1, $urandom);
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h900;
        gq.push_back('{cyc: cyc + 1, addr: 32'h900, we: 1'b0, wdata: mem_wdata});
        streak = 0;
        step();
        step();
        rst = 1'b1;
        step();
        chk("mid_rst_bus_req", {31'd0, bus_req}, 32'd0);
        chk("mid_rst_mem_ready", {31'd0, mem_ready}, 32'd0);
        step();
        check_reset_vals();
        rst = 1'b0;
        mem_req = 1'b0;
        streak = 0;
        step();
        for (int i = 0; i < 20; i++) random_round();
        while (mem_req || if_req) do_txn(1, $urandom);
        step();
        step();
        chk("rsp_queue_drained", rq.size(), 32'd0);
        chk("gnt_queue_drained", gq.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
